// File: rtl/cplq_multi_manager.sv
// Completion-queue manager: polls one of NUM_QUEUES host-memory completion queues until N
// entries with the expected phase are consumed, then rings that queue's head doorbell.
module cplq_multi_manager #(
  parameter int                    NUM_QUEUES       = 4,
  parameter int                    ENTRY_ADDR_WIDTH = 6,
  parameter int                    ENTRY_WIDTH      = 128,
  parameter int                    PHASE_BIT        = 112,
  parameter int                    ADDR_WIDTH       = 32,
  parameter logic [ADDR_WIDTH-1:0] QUEUE_BASE_ADDR  = 32'h7600_0000,
  parameter logic [ADDR_WIDTH-1:0] QUEUE_STRIDE     = 32'h400,
  parameter int                    POLL_GAP         = 4,
  localparam int                   QID_W            = (NUM_QUEUES > 1) ? $clog2(NUM_QUEUES) : 1
) (
  input  logic                        aclk,
  input  logic                        reset,
  input  logic                        go,
  input  logic [QID_W-1:0]            qid,
  input  logic [31:0]                 num_cmds_to_wait,
  output logic                        busy,
  output logic                        done,
  output logic [15:0]                 err_count,
  output logic                        rd_req_valid,
  input  logic                        rd_req_ready,
  output logic [ADDR_WIDTH-1:0]       rd_req_addr,
  input  logic                        rd_rsp_valid,
  input  logic [ENTRY_WIDTH-1:0]      rd_rsp_data,
  output logic                        db_valid,
  input  logic                        db_ready,
  output logic [QID_W-1:0]            db_qid,
  output logic [ENTRY_ADDR_WIDTH-1:0] db_head
);

  localparam int GAP_W = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
  localparam int HI_W  = ENTRY_WIDTH - PHASE_BIT;

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT_RSP, S_CHECK, S_GAP, S_DOORBELL, S_DONE
  } state_t;

  state_t                      state_reg, state_next;
  logic [QID_W-1:0]            qid_reg;
  logic [31:0]                 count_reg;
  logic [HI_W-1:0]             entry_hi_reg;
  logic [GAP_W-1:0]            gap_cnt_reg;
  logic [15:0]                 err_count_reg;
  logic [ENTRY_ADDR_WIDTH-1:0] head_reg [NUM_QUEUES];
  logic [NUM_QUEUES-1:0]       phase_reg;

  logic [QID_W-1:0]            qid_sel;
  logic [ENTRY_ADDR_WIDTH-1:0] cur_head;
  logic                        phase_match;
  logic                        consume;
  logic                        entry_err;
  logic                        unused_rsp_bits;

  // Only the phase tag and status field matter; the rest of the entry is dropped.
  assign unused_rsp_bits = ^rd_rsp_data[PHASE_BIT-1:0];

  assign qid_sel     = ({{(32-QID_W){1'b0}}, qid} < NUM_QUEUES) ? qid : '0;
  assign cur_head    = head_reg[qid_reg];
  assign phase_match = (entry_hi_reg[0] == phase_reg[qid_reg]);
  assign entry_err   = |entry_hi_reg[HI_W-1:1];
  assign consume     = (state_reg == S_CHECK) && phase_match;

  assign busy         = (state_reg != S_IDLE) && (state_reg != S_DONE);
  assign done         = (state_reg == S_DONE);
  assign err_count    = err_count_reg;
  assign rd_req_valid = (state_reg == S_ISSUE);
  assign rd_req_addr  = QUEUE_BASE_ADDR + ADDR_WIDTH'(qid_reg) * QUEUE_STRIDE
                      + (ADDR_WIDTH'(cur_head) << 4);
  assign db_valid     = (state_reg == S_DOORBELL);
  assign db_qid       = qid_reg;
  assign db_head      = cur_head;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:     if (go) state_next = (num_cmds_to_wait == 32'd0) ? S_DOORBELL : S_ISSUE;
      S_ISSUE:    if (rd_req_ready) state_next = S_WAIT_RSP;
      S_WAIT_RSP: if (rd_rsp_valid) state_next = S_CHECK;
      S_CHECK: begin
        if (!phase_match)            state_next = S_GAP;
        else if (count_reg == 32'd1) state_next = S_DOORBELL;
        else                         state_next = S_ISSUE;
      end
      S_GAP:      if (gap_cnt_reg == GAP_W'(POLL_GAP - 1)) state_next = S_ISSUE;
      S_DOORBELL: if (db_ready) state_next = S_DONE;
      S_DONE:     state_next = S_IDLE;
      default:    state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (reset) begin
      state_reg     <= S_IDLE;
      qid_reg       <= '0;
      count_reg     <= '0;
      entry_hi_reg  <= '0;
      gap_cnt_reg   <= '0;
      err_count_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == S_IDLE && go) begin
        qid_reg   <= qid_sel;
        count_reg <= num_cmds_to_wait;
      end
      if (state_reg == S_WAIT_RSP && rd_rsp_valid)
        entry_hi_reg <= rd_rsp_data[ENTRY_WIDTH-1:PHASE_BIT];
      if (consume) begin
        count_reg <= count_reg - 32'd1;
        if (entry_err && err_count_reg != 16'hFFFF)
          err_count_reg <= err_count_reg + 16'd1;
      end
      gap_cnt_reg <= (state_reg == S_GAP) ? gap_cnt_reg + 1'b1 : '0;
    end
  end

  // Per-queue ring state; the phase flips on the same edge the head wraps to 0.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_QUEUES; gi++) begin : g_queue
      always_ff @(posedge aclk) begin
        if (reset) begin
          head_reg[gi]  <= '0;
          phase_reg[gi] <= 1'b1;
        end else if (consume && qid_reg == QID_W'(gi)) begin
          head_reg[gi] <= head_reg[gi] + 1'b1;
          if (&head_reg[gi])
            phase_reg[gi] <= ~phase_reg[gi];
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_cplq_multi_manager.sv
// Randomized bench for cplq_multi_manager: host-memory queue model, fabric responder and a
// transaction-level reference of head/phase/error state per queue.
module tb_cplq_multi_manager;
  localparam int          NQ     = 4;
  localparam int          DEPTH  = 64;
  localparam int          EW     = 128;
  localparam int          PB     = 112;
  localparam int          PG     = 4;
  localparam logic [31:0] BASE   = 32'h7600_0000;
  localparam logic [31:0] STRIDE = 32'h400;

  logic          aclk = 1'b0;
  logic          reset = 1'b1;
  logic          go = 1'b0;
  logic [1:0]    qid = '0;
  logic [31:0]   num_cmds_to_wait = '0;
  logic          busy, done, rd_req_valid, db_valid;
  logic [15:0]   err_count;
  logic          rd_req_ready = 1'b1;
  logic [31:0]   rd_req_addr;
  logic          rd_rsp_valid = 1'b0;
  logic [EW-1:0] rd_rsp_data = '0;
  logic          db_ready = 1'b1;
  logic [1:0]    db_qid;
  logic [5:0]    db_head;

  cplq_multi_manager dut (
    .aclk(aclk), .reset(reset), .go(go), .qid(qid), .num_cmds_to_wait(num_cmds_to_wait),
    .busy(busy), .done(done), .err_count(err_count),
    .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready), .rd_req_addr(rd_req_addr),
    .rd_rsp_valid(rd_rsp_valid), .rd_rsp_data(rd_rsp_data),
    .db_valid(db_valid), .db_ready(db_ready), .db_qid(db_qid), .db_head(db_head)
  );

  always #5 aclk = ~aclk;

  logic [EW-1:0] mem [NQ][DEPTH];
  int  m_head [NQ];
  bit  m_phase [NQ];
  int  m_err, m_q, m_left;
  int  checks = 0, errors = 0;
  int  cyc = 0, n_done = 0, n_db = 0, n_reads = 0;
  int  done_cyc = 0, last_db_head = 0, last_db_qid = 0, last_acc_cyc = 0;
  bit  pending = 0, stray = 0, last_miss = 0, idle_prev = 0;
  bit  rsp_hold = 0, thr = 0;
  logic [EW-1:0] mon_e;
  logic [31:0]   exp_addr;

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step();
    @(negedge aclk);
    #2;
  endtask

  // Fabric responder and reference model; all decisions refer to the upcoming rising edge.
  always @(negedge aclk) begin
    cyc++;
    if (thr) begin
      rd_req_ready = 1'($urandom_range(0, 1));
      db_ready     = 1'($urandom_range(0, 1));
    end else begin
      rd_req_ready = 1'b1;
      db_ready     = 1'b1;
    end
    if (reset) begin
      for (int q = 0; q < NQ; q++) begin
        m_head[q]  = 0;
        m_phase[q] = 1'b1;
      end
      m_err = 0;
      m_left = 0;
      if (pending) stray = 1;
      pending = 0;
      last_miss = 0;
    end else if (go && idle_prev) begin
      m_q    = int'(qid);
      m_left = int'(num_cmds_to_wait);
    end
    idle_prev = !busy && !done;
    rd_rsp_valid = 1'b0;
    if (pending && !rsp_hold) begin
      mon_e = mem[m_q][m_head[m_q]];
      rd_rsp_valid = 1'b1;
      rd_rsp_data  = mon_e;
      pending = 0;
      if (mon_e[PB] == m_phase[m_q]) begin
        if (mon_e[EW-1:PB+1] != 0 && m_err < 65535) m_err++;
        m_head[m_q] = (m_head[m_q] + 1) % DEPTH;
        if (m_head[m_q] == 0) m_phase[m_q] = ~m_phase[m_q];
        m_left--;
        last_miss = 0;
      end else begin
        last_miss = 1;
      end
    end else if (stray && !rsp_hold && !reset) begin
      rd_rsp_valid = 1'b1;
      rd_rsp_data  = '1;
      stray = 0;
    end
    if (rd_req_valid) begin
      exp_addr = BASE + 32'(m_q) * STRIDE + 32'(m_head[m_q]) * 32'd16;
      check("rd_addr", rd_req_addr, exp_addr);
      if (rd_req_ready) begin
        if (last_miss) check("poll_gap", (cyc - last_acc_cyc) >= PG + 3, 1);
        pending = 1;
        n_reads++;
        last_acc_cyc = cyc;
      end
    end
    if (db_valid && db_ready) begin
      check("db_qid", db_qid, m_q);
      check("db_head", db_head, m_head[m_q]);
      check("db_left", m_left, 0);
      last_db_head = int'(db_head);
      last_db_qid  = int'(db_qid);
      n_db++;
    end
    if (done) begin
      n_done++;
      done_cyc = cyc;
    end
  end

  task automatic fill(input int q, input int n, input int err_pct);
    int h;
    bit p;
    logic [EW-1:0] e;
    h = m_head[q];
    p = m_phase[q];
    for (int i = 0; i < n; i++) begin
      e = {$urandom(), $urandom(), $urandom(), $urandom()};
      e[EW-1:PB+1] = ($urandom_range(0, 99) < err_pct) ? 15'($urandom_range(1, 32767)) : 15'd0;
      e[PB] = p;
      mem[q][h] = e;
      h = (h + 1) % DEPTH;
      if (h == 0) p = ~p;
    end
    mem[q][h][PB] = ~p;
  endtask

  task automatic run_cmd(input int q, input int n, input bit chk_lat);
    int d0, db0, g, t;
    step();
    go = 1'b1;
    qid = 2'(q);
    num_cmds_to_wait = 32'(n);
    d0 = n_done;
    db0 = n_db;
    g = cyc;
    step();
    go = 1'b0;
    t = 0;
    while (n_done == d0 && t < 20000) begin
      step();
      t++;
    end
    check("done_seen", n_done != d0, 1);
    if (chk_lat) check("latency", done_cyc - g, 3 * n + 2);
    repeat (3) step();
    check("done_once", n_done - d0, 1);
    check("db_once", n_db - db0, 1);
    check("err_count", err_count, m_err);
    check("busy_after", busy, 0);
    $display("cmd q=%0d n=%0d db_head=%0d err_count=%0d", q, n, last_db_head, err_count);
  endtask

  initial begin
    int r0, d0, db0, t, q, n;
    for (int i = 0; i < NQ; i++)
      for (int j = 0; j < DEPTH; j++) mem[i][j] = '0;
    repeat (3) step();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err_count, 0);
    check("rst_rdv", rd_req_valid, 0);
    check("rst_dbv", db_valid, 0);
    reset = 1'b0;

    // Three clean entries on queue 0.
    r0 = n_reads;
    fill(0, 3, 0);
    run_cmd(0, 3, 1);
    check("t1_reads", n_reads - r0, 3);
    check("t1_head", last_db_head, 3);

    // Wrap 63 -> 0 with phase toggle.
    fill(0, 63, 0);
    run_cmd(0, 63, 1);
    check("t2_head", last_db_head, 2);

    // Stale entry on queue 2 becomes valid after 20 cycles.
    r0 = n_reads;
    mem[2][0] = '0;
    fork
      run_cmd(2, 1, 0);
      begin
        repeat (20) step();
        mem[2][0][PB] = 1'b1;
      end
    join
    check("t3_polled", n_reads - r0 > 1, 1);
    check("t3_qid", last_db_qid, 2);
    check("t3_head", last_db_head, 1);

    // Error status entries under throttling.
    fill(3, 3, 0);
    mem[3][0][EW-1:PB+1] = 15'd2;
    mem[3][2][EW-1:PB+1] = 15'd2;
    thr = 1;
    run_cmd(3, 3, 0);
    thr = 0;
    check("t4_err", err_count, 2);

    // Zero-count commands ring the unchanged head of every queue.
    r0 = n_reads;
    for (int i = 0; i < NQ; i++) run_cmd(i, 0, 1);
    check("t5_noreads", n_reads - r0, 0);

    // go while busy is ignored.
    fill(1, 2, 0);
    fork
      run_cmd(1, 2, 1);
      begin
        repeat (4) step();
        go = 1'b1;
        qid = 2'd0;
        num_cmds_to_wait = 32'd0;
        step();
        go = 1'b0;
      end
    join
    check("t5_busy_go_q", last_db_qid, 1);

    // Reset while waiting for a response; the response arrives late.
    mem[1][0] = '0;
    mem[1][0][PB] = 1'b1;
    rsp_hold = 1;
    r0 = n_reads;
    d0 = n_done;
    db0 = n_db;
    step();
    go = 1'b1;
    qid = 2'd1;
    num_cmds_to_wait = 32'd1;
    step();
    go = 1'b0;
    t = 0;
    while (n_reads == r0 && t < 50) begin
      step();
      t++;
    end
    check("t6_read_seen", n_reads - r0, 1);
    step();
    reset = 1'b1;
    repeat (2) step();
    reset = 1'b0;
    rsp_hold = 0;
    repeat (10) step();
    check("t6_no_done", n_done - d0, 0);
    check("t6_no_db", n_db - db0, 0);
    check("t6_busy", busy, 0);
    check("t6_err", err_count, 0);
    run_cmd(1, 1, 1);
    check("t6_head", last_db_head, 1);

    // Random commands across all queues.
    for (int k = 0; k < 12; k++) begin
      q = int'($urandom_range(0, NQ - 1));
      n = int'($urandom_range(0, 8));
      thr = 1'($urandom_range(0, 1));
      fill(q, n, 30);
      run_cmd(q, n, !thr);
    end
    thr = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
